// File: rtl/key_schedule_pkg.sv
// Shared types and helpers for the runtime-configurable AES key schedule.
package key_schedule_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_RSV = 2'd3
  } keylen_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EXPAND = 3'd2,
    ST_READY  = 3'd3,
    ST_STREAM = 3'd4
  } state_e;

  // Largest round count the store must hold for a given maximum key length.
  function automatic int nrmax_of(int kmax);
    return kmax / 32 + 6;
  endfunction

  // Reserved encoding behaves as a 256-bit key.
  function automatic logic [3:0] nk_of(keylen_e kl);
    case (kl)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(keylen_e kl);
    case (kl)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [5:0] nw_of(keylen_e kl);
    return {nr_of(kl) + 4'd1, 2'b00};
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t rot_word(word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_schedule_if.sv
// Round-key stream channel between the key schedule and the cipher datapath.
interface key_schedule_if;
  logic         rk_start;
  logic         rk_dir;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] roundKey;
  logic [3:0]   rk_idx;
  logic         rk_last;

  modport master (
    input  rk_start, rk_dir, rk_ready,
    output rk_valid, roundKey, rk_idx, rk_last
  );

  modport slave (
    output rk_start, rk_dir, rk_ready,
    input  rk_valid, roundKey, rk_idx, rk_last
  );
endinterface

// File: rtl/key_schedule_subword.sv
// SubWord: four parallel AES S-box lookups on one 32-bit word.
module key_schedule_subword
  import key_schedule_pkg::*;
(
  input  word_t din,
  output word_t dout
);

  // Byte 0x00 sits in the top byte, so entry b lives at bit {~b, 3'b111}.
  localparam logic [2047:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  // Byte-wise substitution, purely combinational.
  always_comb begin
    dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};
  end

endmodule

// File: rtl/key_schedule.sv
// Runtime-configurable AES key schedule: expands one word per cycle into a
// flop store, then streams round keys forward or reverse on request.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no valid schedule; waits for start
//   ST_LOAD   | key words w[0..Nk-1] written into the store
//   ST_EXPAND | one schedule word w[i] produced per cycle until w[Nw-1]
//   ST_READY  | schedule held; accepts re-key (start) or a stream request
//   ST_STREAM | round keys presented under valid/ready, one per beat
module key_schedule
  import key_schedule_pkg::*;
#(
  parameter int KMAX = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      keylen,
  input  logic [KMAX-1:0] key,
  output logic            busy,
  output logic            keyready,
  output logic            cfg_err,
  key_schedule_if.master  rk
);

  localparam int NRMAX = nrmax_of(KMAX);
  localparam int NKMAX = KMAX / 32;
  localparam int NWMAX = 4 * (NRMAX + 1);

  state_e       state;
  word_t        store [NWMAX];
  logic [5:0]   widx;
  logic [2:0]   phase;
  logic [7:0]   rcon;
  logic [3:0]   nk;
  logic [3:0]   nr;
  logic [5:0]   nw;
  logic [3:0]   ridx;
  logic         dir;

  word_t        w_prev;
  word_t        w_back;
  word_t        sub_in;
  word_t        sub_out;
  word_t        temp;
  word_t        w_new;
  logic [3:0]   r_next;
  logic         dir_sel;
  logic         last_next;
  logic [127:0] rd_key;
  logic         key_fits;

  assign key_fits = (32 * int'(nk_of(keylen_e'(keylen)))) <= KMAX;

  // Operand fetch for w[i]; RotWord is only applied on the phase-0 word.
  always_comb begin
    w_prev = store[widx - 6'd1];
    w_back = store[widx - {2'b00, nk}];
    sub_in = (phase == 3'd0) ? rot_word(w_prev) : w_prev;
  end

  key_schedule_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  // Select the mixed word and form the next schedule word.
  always_comb begin
    if (phase == 3'd0) begin
      temp = sub_out ^ {rcon, 24'h0};
    end else if (nk == 4'd8 && phase == 3'd4) begin
      temp = sub_out;
    end else begin
      temp = w_prev;
    end
    w_new = w_back ^ temp;
  end

  // Next round index: the first beat when starting, otherwise a +/-1 step.
  always_comb begin
    if (state == ST_STREAM) begin
      dir_sel = dir;
      r_next  = dir ? (ridx - 4'd1) : (ridx + 4'd1);
    end else begin
      dir_sel = rk.rk_dir;
      r_next  = rk.rk_dir ? nr : 4'd0;
    end
    last_next = dir_sel ? (r_next == 4'd0) : (r_next == nr);
    rd_key    = {store[{r_next, 2'b00}], store[{r_next, 2'b01}],
                 store[{r_next, 2'b10}], store[{r_next, 2'b11}]};
  end

  // Store write port; left unreset, its contents only matter after LOAD.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD) begin
      for (int k = 0; k < NKMAX; k++) begin
        if (k < int'(nk)) store[k] <= key[KMAX-1-32*k -: 32];
      end
    end else if (state == ST_EXPAND) begin
      store[widx] <= w_new;
    end
  end

  // Control FSM with all handshake and status outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      keyready    <= 1'b0;
      cfg_err     <= 1'b0;
      rk.rk_valid <= 1'b0;
      rk.roundKey <= '0;
      rk.rk_idx   <= '0;
      rk.rk_last  <= 1'b0;
      widx        <= '0;
      phase       <= '0;
      rcon        <= '0;
      nk          <= 4'd4;
      nr          <= 4'd10;
      nw          <= 6'd44;
      ridx        <= '0;
      dir         <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE, ST_READY: begin
          if (start && key_fits) begin
            state    <= ST_LOAD;
            busy     <= 1'b1;
            keyready <= 1'b0;
            nk       <= nk_of(keylen_e'(keylen));
            nr       <= nr_of(keylen_e'(keylen));
            nw       <= nw_of(keylen_e'(keylen));
          end else begin
            if (start) cfg_err <= 1'b1;
            if (state == ST_READY && rk.rk_start) begin
              state       <= ST_STREAM;
              busy        <= 1'b1;
              dir         <= rk.rk_dir;
              ridx        <= r_next;
              rk.rk_valid <= 1'b1;
              rk.roundKey <= rd_key;
              rk.rk_idx   <= r_next;
              rk.rk_last  <= last_next;
            end
          end
        end
        ST_LOAD: begin
          state <= ST_EXPAND;
          widx  <= {2'b00, nk};
          phase <= 3'd0;
          rcon  <= 8'h01;
        end
        ST_EXPAND: begin
          widx  <= widx + 6'd1;
          phase <= ({1'b0, phase} == nk - 4'd1) ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0) rcon <= xtime(rcon);
          if (widx == nw - 6'd1) begin
            state    <= ST_READY;
            busy     <= 1'b0;
            keyready <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (rk.rk_ready) begin
            if (rk.rk_last) begin
              state       <= ST_READY;
              busy        <= 1'b0;
              rk.rk_valid <= 1'b0;
              rk.roundKey <= '0;
              rk.rk_idx   <= '0;
              rk.rk_last  <= 1'b0;
            end else begin
              ridx        <= r_next;
              rk.roundKey <= rd_key;
              rk.rk_idx   <= r_next;
              rk.rk_last  <= last_next;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: scoreboard of expected round keys
// built from an independent behavioural expansion model.
module tb_key_schedule;
  import key_schedule_pkg::*;

  localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K128B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192B = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start;
  logic [1:0]   keylen;
  logic [255:0] key;
  logic         busy, keyready, cfg_err;

  logic         start_s;
  logic [1:0]   keylen_s;
  logic [127:0] key_s;
  logic         busy_s, keyready_s, cfg_err_s;

  key_schedule_if rk_if ();
  key_schedule_if rk_if_s ();

  key_schedule #(.KMAX(256)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .keylen   (keylen),
    .key      (key),
    .busy     (busy),
    .keyready (keyready),
    .cfg_err  (cfg_err),
    .rk       (rk_if)
  );

  key_schedule #(.KMAX(128)) dut_s (
    .clk      (clk),
    .reset    (reset),
    .start    (start_s),
    .keylen   (keylen_s),
    .key      (key_s),
    .busy     (busy_s),
    .keyready (keyready_s),
    .cfg_err  (cfg_err_s),
    .rk       (rk_if_s)
  );

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] k;
    logic         last;
  } beat_t;

  beat_t        sb [$];
  logic [7:0]   sbm [256];
  logic [31:0]  wm [60];
  logic [127:0] cap [16];
  int           total = 0;
  int           bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse plus affine map, independent of the RTL table.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbm[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(logic [31:0] t);
    return {sbm[t[31:24]], sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]]};
  endfunction

  task automatic model_expand(input int nk, input logic [255:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    int          nw;
    nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) wm[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < nw; i++) begin
      t = wm[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      wm[i] = wm[i-nk] ^ t;
    end
  endtask

  task automatic load_key(input logic [1:0] kl, input logic [255:0] k, input int want,
                          input bit poke, input string tag);
    int   cyc;
    logic seen_valid;
    model_expand((kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8, k);
    keylen = kl;
    key    = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    cyc    = 1;
    seen_valid = 1'b0;
    total++;
    if (keyready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s load_state: keyready=%b busy=%b want 0/1", tag, keyready, busy);
    end
    while (keyready !== 1'b1 && cyc < 300) begin
      rk_if.rk_start = poke && cyc >= 2 && cyc < 12;
      rk_if.rk_dir   = 1'b0;
      tick();
      cyc++;
      seen_valid = seen_valid | rk_if.rk_valid;
    end
    rk_if.rk_start = 1'b0;
    total++;
    if (cyc != want) begin
      bad++;
      $display("FAIL %s keyready_cycle: got %0d want %0d", tag, cyc, want);
    end
    if (poke) begin
      total++;
      if (seen_valid !== 1'b0 || rk_if.rk_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s rk_start_in_expand: rk_valid seen=%b want 0", tag, seen_valid);
      end
    end
  endtask

  task automatic run_stream(input logic d, input int nr, input int bp_pct, input string tag);
    beat_t        b;
    int           guard;
    logic         pend;
    logic [127:0] hk;
    logic [3:0]   hi;
    logic         hl;
    for (int j = 0; j <= nr; j++) begin
      int r;
      r      = d ? nr - j : j;
      b.idx  = 4'(r);
      b.k    = {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
      b.last = (j == nr);
      sb.push_back(b);
    end
    rk_if.rk_dir   = d;
    rk_if.rk_start = 1'b1;
    tick();
    rk_if.rk_start = 1'b0;
    total++;
    if (rk_if.rk_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s first_valid: got %b want 1", tag, rk_if.rk_valid);
    end
    pend  = 1'b0;
    guard = 0;
    hk = '0; hi = '0; hl = 1'b0;
    while (sb.size() > 0 && guard < 1000) begin
      if (pend) begin
        total++;
        if ({rk_if.rk_valid, rk_if.roundKey, rk_if.rk_idx, rk_if.rk_last} !== {1'b1, hk, hi, hl}) begin
          bad++;
          $display("FAIL %s hold: got v=%b idx=%0d key=%h want idx=%0d key=%h", tag,
                   rk_if.rk_valid, rk_if.rk_idx, rk_if.roundKey, hi, hk);
        end
      end
      rk_if.rk_ready = ($urandom_range(0, 99) >= bp_pct);
      if (rk_if.rk_valid && rk_if.rk_ready) begin
        b = sb.pop_front();
        cap[b.idx] = rk_if.roundKey;
        total++;
        if (rk_if.roundKey !== b.k) begin
          bad++;
          $display("FAIL %s key r=%0d: got %h want %h", tag, b.idx, rk_if.roundKey, b.k);
        end
        total++;
        if (rk_if.rk_idx !== b.idx) begin
          bad++;
          $display("FAIL %s idx: got %0d want %0d", tag, rk_if.rk_idx, b.idx);
        end
        total++;
        if (rk_if.rk_last !== b.last) begin
          bad++;
          $display("FAIL %s last r=%0d: got %b want %b", tag, b.idx, rk_if.rk_last, b.last);
        end
        pend = 1'b0;
      end else if (rk_if.rk_valid) begin
        pend = 1'b1;
        hk = rk_if.roundKey;
        hi = rk_if.rk_idx;
        hl = rk_if.rk_last;
      end
      tick();
      guard++;
    end
    rk_if.rk_ready = 1'b0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s stream_timeout: %0d beats left want 0", tag, sb.size());
    end
    sb.delete();
    total++;
    if (rk_if.rk_valid !== 1'b0 || keyready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s ready_return: valid=%b keyready=%b busy=%b want 0/1/0", tag,
               rk_if.rk_valid, keyready, busy);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({busy, keyready, cfg_err, rk_if.rk_valid, rk_if.rk_last, rk_if.roundKey, rk_if.rk_idx} !== '0) begin
      bad++;
      $display("FAIL reset_main: busy=%b kr=%b err=%b v=%b last=%b key=%h idx=%0d want all 0",
               busy, keyready, cfg_err, rk_if.rk_valid, rk_if.rk_last, rk_if.roundKey, rk_if.rk_idx);
    end
    total++;
    if ({busy_s, keyready_s, cfg_err_s, rk_if_s.rk_valid, rk_if_s.roundKey} !== '0) begin
      bad++;
      $display("FAIL reset_small: busy=%b kr=%b err=%b v=%b want all 0",
               busy_s, keyready_s, cfg_err_s, rk_if_s.rk_valid);
    end
  endtask

  task automatic test_aes128();
    load_key(2'd0, {K128, 128'h0}, 42, 1'b0, "aes128");
    run_stream(1'b0, 10, 0, "aes128");
    total++;
    if (cap[0] !== K128) begin
      bad++;
      $display("FAIL aes128_round0: got %h want %h", cap[0], K128);
    end
    total++;
    if (cap[10] !== R128_10) begin
      bad++;
      $display("FAIL aes128_round10: got %h want %h", cap[10], R128_10);
    end
  endtask

  task automatic test_aes192();
    load_key(2'd1, {K192, 64'h0}, 48, 1'b0, "aes192");
    run_stream(1'b1, 12, 0, "aes192");
    total++;
    if (cap[12] !== R192_12) begin
      bad++;
      $display("FAIL aes192_round12: got %h want %h", cap[12], R192_12);
    end
    total++;
    if (cap[0] !== K192[191:64]) begin
      bad++;
      $display("FAIL aes192_round0: got %h want %h", cap[0], K192[191:64]);
    end
  endtask

  task automatic test_aes256_backpressure();
    load_key(2'd2, K256, 54, 1'b0, "aes256");
    run_stream(1'b0, 14, 40, "aes256_bp");
    total++;
    if (cap[14] !== R256_14) begin
      bad++;
      $display("FAIL aes256_round14: got %h want %h", cap[14], R256_14);
    end
  endtask

  task automatic test_back_to_back();
    run_stream(1'b1, 14, 30, "b2b_rev");
    run_stream(1'b0, 14, 0, "b2b_fwd");
  endtask

  task automatic test_rk_start_in_expand();
    load_key(2'd0, {K128B, 128'h0}, 42, 1'b1, "expand_poke");
    run_stream(1'b0, 10, 20, "expand_poke");
  endtask

  task automatic test_rekey();
    load_key(2'd1, {K192B, 64'h0}, 48, 1'b0, "rekey192");
    run_stream(1'b0, 12, 0, "rekey192");
    load_key(2'd3, K256, 54, 1'b0, "rekey_rsv");
    run_stream(1'b1, 14, 0, "rekey_rsv");
  endtask

  task automatic test_reset_mid();
    keylen = 2'd0;
    key    = {K128, 128'h0};
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (20) tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pre: busy=%b want 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({busy, keyready, cfg_err, rk_if.rk_valid, rk_if.rk_last, rk_if.roundKey, rk_if.rk_idx} !== '0) begin
      bad++;
      $display("FAIL reset_mid_async: busy=%b kr=%b v=%b want all 0", busy, keyready, rk_if.rk_valid);
    end
    tick();
    reset = 1'b1;
    tick();
    load_key(2'd0, {K128, 128'h0}, 42, 1'b0, "after_reset");
    run_stream(1'b0, 10, 0, "after_reset");
    total++;
    if (cap[10] !== R128_10) begin
      bad++;
      $display("FAIL after_reset_round10: got %h want %h", cap[10], R128_10);
    end
  endtask

  task automatic test_cfg_err();
    int cyc;
    keylen_s = 2'd2;
    key_s    = K128;
    start_s  = 1'b1;
    tick();
    start_s  = 1'b0;
    total++;
    if (cfg_err_s !== 1'b1 || busy_s !== 1'b0 || keyready_s !== 1'b0) begin
      bad++;
      $display("FAIL cfg_err_pulse: err=%b busy=%b kr=%b want 1/0/0", cfg_err_s, busy_s, keyready_s);
    end
    tick();
    total++;
    if (cfg_err_s !== 1'b0 || busy_s !== 1'b0) begin
      bad++;
      $display("FAIL cfg_err_once: err=%b busy=%b want 0/0", cfg_err_s, busy_s);
    end
    keylen_s = 2'd0;
    start_s  = 1'b1;
    tick();
    start_s  = 1'b0;
    cyc = 1;
    total++;
    if (cfg_err_s !== 1'b0 || busy_s !== 1'b1) begin
      bad++;
      $display("FAIL small_valid_start: err=%b busy=%b want 0/1", cfg_err_s, busy_s);
    end
    while (keyready_s !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc != 42) begin
      bad++;
      $display("FAIL small_keyready_cycle: got %0d want 42", cyc);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    keylen = 2'd0;
    key = '0;
    start_s = 1'b0;
    keylen_s = 2'd0;
    key_s = '0;
    rk_if.rk_start = 1'b0;
    rk_if.rk_dir = 1'b0;
    rk_if.rk_ready = 1'b0;
    rk_if_s.rk_start = 1'b0;
    rk_if_s.rk_dir = 1'b0;
    rk_if_s.rk_ready = 1'b0;
    build_sbox();
    repeat (2) tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_aes128();
    test_aes192();
    test_aes256_backpressure();
    test_back_to_back();
    test_rk_start_in_expand();
    test_rekey();
    test_reset_mid();
    test_cfg_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
